// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: one allocate, one writeback and one retire per cycle.
// Optional ROB_EARLY_FULL_EN raises rob_full one entry early (count >= DEPTH-1).
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [AREG_W-1:0] alloc_areg,
    input  logic [PREG_W-1:0] alloc_preg,
    input  logic [PREG_W-1:0] alloc_old_preg,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              alloc_accept,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              wb_exception,
    input  logic              commit_ready,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              commit_has_dest,
    output logic [AREG_W-1:0] commit_areg,
    output logic [PREG_W-1:0] commit_preg,
    output logic [PREG_W-1:0] commit_old_preg,
    output logic              commit_exception,
    input  logic              flush,
    output logic              rob_full,
    output logic              rob_empty,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] L_FULL_XOR = {1'b1, {TAG_W{1'b0}}};
    localparam logic [TAG_W:0] L_ONE      = (TAG_W+1)'(1);

    logic [TAG_W:0]      r_head;
    logic [TAG_W:0]      r_tail;
    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH-1:0]    r_done;
    logic [DEPTH-1:0]    r_exc;
    logic [DEPTH-1:0]    r_has_dest;
    logic [AREG_W-1:0]   r_areg     [DEPTH];
    logic [PREG_W-1:0]   r_preg     [DEPTH];
    logic [PREG_W-1:0]   r_old_preg [DEPTH];

    logic [TAG_W-1:0]    w_head_idx;
    logic [TAG_W-1:0]    w_tail_idx;
    logic [TAG_W:0]      w_count;
    logic                w_full;
    logic                w_retire;
    logic                w_clear;

    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];
    assign w_count    = r_tail - r_head;
    assign w_full     = ((r_head ^ r_tail) == L_FULL_XOR);

    assign alloc_tag    = w_tail_idx;
    assign alloc_accept = alloc_valid && !w_full;

    assign commit_valid     = r_valid[w_head_idx] && r_done[w_head_idx];
    assign commit_tag       = w_head_idx;
    assign commit_has_dest  = r_has_dest[w_head_idx];
    assign commit_areg      = r_areg[w_head_idx];
    assign commit_preg      = r_preg[w_head_idx];
    assign commit_old_preg  = r_old_preg[w_head_idx];
    assign commit_exception = r_exc[w_head_idx];

    assign w_retire = commit_valid && commit_ready;
    // A faulting retire discards everything younger, exactly like a flush.
    assign w_clear  = reset || flush || (w_retire && commit_exception);

    assign count     = w_count;
    assign rob_empty = (r_head == r_tail);

`ifdef ROB_EARLY_FULL_EN
    localparam logic [TAG_W:0] L_DEPTH_M1 = (TAG_W+1)'(DEPTH - 1);
    assign rob_full = (w_count >= L_DEPTH_M1);
`else
    assign rob_full = w_full;
`endif

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_exc   <= '0;
        end else begin
            if (wb_valid && r_valid[wb_tag]) begin
                r_done[wb_tag] <= 1'b1;
                r_exc[wb_tag]  <= wb_exception;
            end
            if (w_retire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_head              <= r_head + L_ONE;
            end
            // The tail slot is never valid when accepted, so it cannot collide with wb or retire.
            if (alloc_accept) begin
                r_valid[w_tail_idx]    <= 1'b1;
                r_done[w_tail_idx]     <= 1'b0;
                r_exc[w_tail_idx]      <= 1'b0;
                r_has_dest[w_tail_idx] <= alloc_has_dest;
                r_areg[w_tail_idx]     <= alloc_areg;
                r_preg[w_tail_idx]     <= alloc_preg;
                r_old_preg[w_tail_idx] <= alloc_old_preg;
                r_tail                 <= r_tail + L_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue model.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset, alloc_valid, alloc_has_dest;
    logic [4:0] alloc_areg;
    logic [5:0] alloc_preg, alloc_old_preg;
    logic [3:0] alloc_tag;
    logic       alloc_accept;
    logic       wb_valid, wb_exception, commit_ready, flush;
    logic [3:0] wb_tag;
    logic       commit_valid, commit_has_dest, commit_exception;
    logic [3:0] commit_tag;
    logic [4:0] commit_areg;
    logic [5:0] commit_preg, commit_old_preg;
    logic       rob_full, rob_empty;
    logic [4:0] count;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest),
        .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
        .alloc_tag(alloc_tag), .alloc_accept(alloc_accept),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exception(wb_exception),
        .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_has_dest(commit_has_dest), .commit_areg(commit_areg),
        .commit_preg(commit_preg), .commit_old_preg(commit_old_preg),
        .commit_exception(commit_exception), .flush(flush),
        .rob_full(rob_full), .rob_empty(rob_empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] tag;
        logic       hd;
        logic [4:0] areg;
        logic [5:0] preg;
        logic [5:0] old;
        logic       done;
        logic       exc;
    } ent_t;

    ent_t       q[$];
    logic [4:0] m_tail;
    bit         started = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: oldest-first queue, applied at each rising edge.
    always @(posedge clk) begin
        bit   ret, ex, acc;
        ent_t e;
        if (reset || flush) begin
            q.delete();
            m_tail  = 0;
            started = 1;
        end else if (started) begin
            ret = (q.size() > 0) && q[0].done && commit_ready;
            ex  = ret && q[0].exc;
            acc = alloc_valid && (q.size() < DEPTH);
            if (ex) begin
                q.delete();
                m_tail = 0;
            end else begin
                if (wb_valid) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].tag == wb_tag) begin
                            e = q[i]; e.done = 1'b1; e.exc = wb_exception; q[i] = e;
                        end
                    end
                end
                if (ret) void'(q.pop_front());
                if (acc) begin
                    e.tag = m_tail[3:0]; e.hd = alloc_has_dest; e.areg = alloc_areg;
                    e.preg = alloc_preg; e.old = alloc_old_preg; e.done = 0; e.exc = 0;
                    q.push_back(e);
                    m_tail = m_tail + 5'd1;
                end
            end
        end
    end

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        int  n;
        bit  cv;
        if (started) begin
            n  = q.size();
            cv = (n > 0) && q[0].done;
            chk("count", count, n);
            chk("rob_empty", rob_empty, n == 0);
`ifdef ROB_EARLY_FULL_EN
            chk("rob_full", rob_full, n >= DEPTH - 1);
`else
            chk("rob_full", rob_full, n == DEPTH);
`endif
            chk("alloc_tag", alloc_tag, m_tail[3:0]);
            chk("alloc_accept", alloc_accept, alloc_valid && (n < DEPTH));
            chk("commit_valid", commit_valid, cv);
            if (cv) begin
                chk("commit_tag", commit_tag, q[0].tag);
                chk("commit_has_dest", commit_has_dest, q[0].hd);
                chk("commit_areg", commit_areg, q[0].areg);
                chk("commit_preg", commit_preg, q[0].preg);
                chk("commit_old_preg", commit_old_preg, q[0].old);
                chk("commit_exception", commit_exception, q[0].exc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alloc_valid = 0; wb_valid = 0; wb_exception = 0; commit_ready = 0; flush = 0;
    endtask

    task automatic alloc_n(input int base);
        alloc_valid    = 1;
        alloc_has_dest = 1;
        alloc_areg     = 5'(base + 1);
        alloc_preg     = 6'(base + 10);
        alloc_old_preg = 6'(base + 20);
    endtask

    initial begin
        reset = 1; idle();
        alloc_has_dest = 0; alloc_areg = 0; alloc_preg = 0; alloc_old_preg = 0; wb_tag = 0;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", rob_empty, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_alloc_tag", alloc_tag, 0);

        // Fill with 16 allocations, no writeback.
        for (int i = 0; i < DEPTH; i++) begin
            alloc_n(i);
            #1;
            chk("fill_tag", alloc_tag, i);
            chk("fill_accept", alloc_accept, 1);
`ifdef ROB_EARLY_FULL_EN
            chk("fill_full", rob_full, i >= 15);
`else
            chk("fill_full", rob_full, 0);
`endif
            tick();
        end
        #1;
        chk("full_count", count, 16);
        chk("full_flag", rob_full, 1);
        chk("alloc17_accept", alloc_accept, 0);
        alloc_valid = 0; wb_valid = 1; wb_tag = 0;
        tick();
        // Retire while full: no bypass into the allocate.
        wb_valid = 0; commit_ready = 1; alloc_n(40);
        #1;
        chk("full_retire_cv", commit_valid, 1);
        chk("full_retire_accept", alloc_accept, 0);
        tick();
        commit_ready = 0;
        #1;
        chk("after_retire_count", count, 15);
        chk("wrap_alloc_tag", alloc_tag, 0);
        chk("wrap_alloc_accept", alloc_accept, 1);
        tick();
        idle(); #1;
        chk("refill_count", count, 16);

        // Flush together with every other request.
        flush = 1; alloc_valid = 1; wb_valid = 1; wb_tag = 1; commit_ready = 1;
        tick();
        idle(); #1;
        chk("flush_count", count, 0);
        chk("flush_cv", commit_valid, 0);
        chk("flush_alloc_tag", alloc_tag, 0);
        wb_valid = 1; wb_tag = 1;
        tick();
        wb_valid = 0; alloc_n(50); tick(); tick();
        alloc_valid = 0; wb_valid = 1; wb_tag = 0; tick();
        wb_valid = 0; commit_ready = 1; #1;
        chk("late_cv_tag0", commit_valid, 1);
        tick();
        commit_ready = 0; #1;
        chk("late_wb_ignored", commit_valid, 0);
        flush = 1; tick(); idle();

        // Out-of-order completion, in-order retirement.
        for (int i = 0; i < 3; i++) begin alloc_n(i); tick(); end
        idle(); wb_valid = 1; wb_tag = 2; #1;
        chk("ooo_cv_a", commit_valid, 0);
        tick();
        wb_tag = 0; #1;
        chk("ooo_cv_b", commit_valid, 0);
        tick();
        wb_tag = 1; commit_ready = 1; #1;
        chk("ooo_cv_c", commit_valid, 1);
        chk("ooo_tag0", commit_tag, 0);
        chk("ooo_areg0", commit_areg, 1);
        chk("ooo_preg0", commit_preg, 10);
        chk("ooo_old0", commit_old_preg, 20);
        tick();
        wb_valid = 0; #1;
        chk("ooo_tag1", commit_tag, 1);
        chk("ooo_areg1", commit_areg, 2);
        tick(); #1;
        chk("ooo_tag2", commit_tag, 2);
        chk("ooo_old2", commit_old_preg, 22);
        tick();
        idle(); #1;
        chk("ooo_empty", rob_empty, 1);

        // Exception retire discards younger entries.
        flush = 1; tick(); idle();
        for (int i = 0; i < 5; i++) begin alloc_n(i); tick(); end
        idle(); wb_valid = 1; wb_tag = 1; wb_exception = 1; tick();
        wb_tag = 0; wb_exception = 0; tick();
        wb_tag = 2; commit_ready = 1; #1;
        chk("exc_tag0", commit_tag, 0);
        chk("exc_flag0", commit_exception, 0);
        tick();
        wb_valid = 0; #1;
        chk("exc_tag1", commit_tag, 1);
        chk("exc_flag1", commit_exception, 1);
        tick();
        idle(); #1;
        chk("exc_empty", rob_empty, 1);
        chk("exc_count", count, 0);
        chk("exc_cv", commit_valid, 0);

        // Reset in the middle of operation.
        for (int i = 0; i < 7; i++) begin alloc_n(i); tick(); end
        idle(); wb_valid = 1; wb_tag = 3; tick();
        reset = 1; alloc_valid = 1; tick();
        reset = 0; idle(); #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", rob_empty, 1);
        chk("mid_rst_full", rob_full, 0);
        chk("mid_rst_cv", commit_valid, 0);
        chk("mid_rst_tag", alloc_tag, 0);
        alloc_n(0); tick(); idle();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            alloc_valid    = ($urandom_range(0, 99) < 60);
            alloc_has_dest = 1'($urandom);
            alloc_areg     = 5'($urandom);
            alloc_preg     = 6'($urandom);
            alloc_old_preg = 6'($urandom);
            wb_valid       = ($urandom_range(0, 99) < 50);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                wb_tag = q[$urandom_range(0, q.size() - 1)].tag;
            else
                wb_tag = 4'($urandom);
            wb_exception   = ($urandom_range(0, 99) < 8);
            commit_ready   = ($urandom_range(0, 99) < 55);
            flush          = ($urandom_range(0, 999) < 15);
            reset          = ($urandom_range(0, 999) < 4);
            tick();
        end
        reset = 0; idle();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
